// File: rtl/store_commit_buffer_if.sv
// Store-buffer port bundle: store entry, ROB commit, flush/hazard, load query and mem write.
// No state; pure wiring. Modport master is the buffer, slave is the surrounding pipeline.
// Backpressure is carried by full/stall/ld_ready; the bundle itself adds none.
interface store_commit_buffer_if #(
    parameter int DEPTH    = 16,
    parameter int TAG_BITS = 4
);
    logic                       st_valid;
    logic [TAG_BITS-1:0]        st_tag;
    logic [31:0]                st_addr;
    logic [31:0]                st_data;
    logic                       commit_store;
    logic [TAG_BITS-1:0]        commit_tag;
    logic                       flush;
    logic                       stall;
    logic                       ld_ready;
    logic [31:0]                ld_check_addr;
    logic                       ld_conflict;
    logic                       mem_wr_en;
    logic [31:0]                mem_wr_addr;
    logic [31:0]                mem_wr_data;
    logic                       full;
    logic [$clog2(DEPTH):0]     count;
    logic                       err;

    modport master (
        input  st_valid, st_tag, st_addr, st_data, commit_store, commit_tag,
               flush, stall, ld_ready, ld_check_addr,
        output ld_conflict, mem_wr_en, mem_wr_addr, mem_wr_data, full, count, err
    );

    modport slave (
        output st_valid, st_tag, st_addr, st_data, commit_store, commit_tag,
               flush, stall, ld_ready, ld_check_addr,
        input  ld_conflict, mem_wr_en, mem_wr_addr, mem_wr_data, full, count, err
    );
endinterface

// File: rtl/store_commit_buffer.sv
// Circular store buffer: holds executed stores until ROB commit, drains them in order.
// Latency: push at edge N, commit in N+1, mem write presented in N+2 at the earliest.
// Backpressure: drain yields to stall/ld_ready; pushes while full are dropped and flag err.
module store_commit_buffer #(
    parameter int DEPTH    = 16,
    parameter int TAG_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    store_commit_buffer_if.master bus
);
    localparam int IDX = $clog2(DEPTH);
    localparam int PW  = IDX + 1;

    logic                r_valid [DEPTH];
    logic                r_cmtd  [DEPTH];
    logic [TAG_BITS-1:0] r_tag   [DEPTH];
    logic [31:0]         r_addr  [DEPTH];
    logic [31:0]         r_data  [DEPTH];
    logic [PW-1:0]       r_head, r_tail, r_cmt;
    logic                r_err;

    logic [IDX-1:0]   w_head_idx, w_tail_idx, w_cmt_idx;
    logic [PW-1:0]    w_count, w_cmt_nxt, w_unc;
    logic             w_full, w_empty, w_push, w_cmt_ok, w_drain, w_err_set;
    logic [DEPTH-1:0] w_discard;
    logic [IDX-1:0]   w_off;
    logic             w_conf;

    assign w_head_idx = r_head[IDX-1:0];
    assign w_tail_idx = r_tail[IDX-1:0];
    assign w_cmt_idx  = r_cmt[IDX-1:0];

    assign w_count = r_tail - r_head;
    assign w_full  = (w_count == PW'(DEPTH));
    assign w_empty = (r_head == r_tail);

    assign w_push    = bus.st_valid & ~w_full & ~bus.flush;
    assign w_cmt_ok  = bus.commit_store & (r_cmt != r_tail) & (r_tag[w_cmt_idx] == bus.commit_tag);
    assign w_drain   = r_valid[w_head_idx] & r_cmtd[w_head_idx] & ~bus.stall & ~bus.ld_ready;
    assign w_err_set = (bus.st_valid & w_full) | (bus.commit_store & ~w_cmt_ok);

    // Flush keeps everything up to the post-commit cmt; the rest of [cmt, tail) is discarded.
    assign w_cmt_nxt = r_cmt + PW'(w_cmt_ok);
    assign w_unc     = r_tail - w_cmt_nxt;

    always_comb begin
        w_discard = '0;
        w_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off        = IDX'(i) - w_cmt_nxt[IDX-1:0];
            w_discard[i] = bus.flush & ({1'b0, w_off} < w_unc);
        end
    end

    always_comb begin
        w_conf = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == bus.ld_check_addr)) w_conf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cmt  <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_cmtd[i]  <= 1'b0;
            end
        end else begin
            if (w_err_set) r_err <= 1'b1;
            if (w_cmt_ok)  r_cmtd[w_cmt_idx] <= 1'b1;
            r_cmt <= w_cmt_nxt;
            if (w_drain) begin
                r_valid[w_head_idx] <= 1'b0;
                r_cmtd[w_head_idx]  <= 1'b0;
                r_head              <= r_head + PW'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_discard[i]) r_valid[i] <= 1'b0;
            end
            if (w_push) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_cmtd[w_tail_idx]  <= 1'b0;
                r_tag[w_tail_idx]   <= bus.st_tag;
                r_addr[w_tail_idx]  <= bus.st_addr;
                r_data[w_tail_idx]  <= bus.st_data;
                r_tail              <= r_tail + PW'(1);
            end else if (bus.flush) begin
                r_tail <= w_cmt_nxt;
            end
        end
    end

    assign bus.mem_wr_en   = w_drain;
    assign bus.mem_wr_addr = w_empty ? 32'd0 : r_addr[w_head_idx];
    assign bus.mem_wr_data = w_empty ? 32'd0 : r_data[w_head_idx];
    assign bus.full        = w_full;
    assign bus.count       = w_count;
    assign bus.ld_conflict = w_conf;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_commit_buffer;
    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    store_commit_buffer_if #(.DEPTH(16), .TAG_BITS(4)) bus ();

    store_commit_buffer #(.DEPTH(16), .TAG_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
        bit          cm;
    } ent_t;

    ent_t mq[$];
    bit   m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an ordered list of pending stores; committed ones form a prefix.
    always @(posedge clk) begin
        int  ncm;
        bit  pre_full;
        bit  drain;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            pre_full = (mq.size() == 16);
            drain    = (mq.size() > 0) && mq[0].cm && !bus.stall && !bus.ld_ready;
            ncm = 0;
            foreach (mq[i]) if (mq[i].cm) ncm++;
            if (bus.commit_store) begin
                if (ncm < mq.size() && mq[ncm].tag == bus.commit_tag) mq[ncm].cm = 1'b1;
                else m_err = 1'b1;
            end
            if (drain) void'(mq.pop_front());
            if (bus.flush) begin
                while (mq.size() > 0 && !mq[mq.size()-1].cm) void'(mq.pop_back());
            end
            if (bus.st_valid) begin
                if (pre_full) m_err = 1'b1;
                else if (!bus.flush) begin
                    e.tag  = bus.st_tag;
                    e.addr = bus.st_addr;
                    e.data = bus.st_data;
                    e.cm   = 1'b0;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit exp_en;
        bit exp_conf;
        if (rst_n) begin
            exp_en   = (mq.size() > 0) && mq[0].cm && !bus.stall && !bus.ld_ready;
            exp_conf = 1'b0;
            foreach (mq[i]) if (mq[i].addr == bus.ld_check_addr) exp_conf = 1'b1;
            chk("m_wr_en",  {31'd0, bus.mem_wr_en}, {31'd0, exp_en});
            chk("m_wr_addr", bus.mem_wr_addr, mq.size() > 0 ? mq[0].addr : 32'd0);
            chk("m_wr_data", bus.mem_wr_data, mq.size() > 0 ? mq[0].data : 32'd0);
            chk("m_count",  {27'd0, bus.count}, mq.size());
            chk("m_full",   {31'd0, bus.full}, {31'd0, mq.size() == 16});
            chk("m_conf",   {31'd0, bus.ld_conflict}, {31'd0, exp_conf});
            chk("m_err",    {31'd0, bus.err}, {31'd0, m_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.st_valid     = 1'b0;
        bus.st_tag       = '0;
        bus.st_addr      = '0;
        bus.st_data      = '0;
        bus.commit_store = 1'b0;
        bus.commit_tag   = '0;
        bus.flush        = 1'b0;
        bus.stall        = 1'b0;
        bus.ld_ready     = 1'b0;
    endtask

    task automatic push(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_tag   = t;
        bus.st_addr  = a;
        bus.st_data  = d;
        step();
        bus.st_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] t);
        bus.commit_store = 1'b1;
        bus.commit_tag   = t;
        step();
        bus.commit_store = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        bus.ld_check_addr = 32'h0;
        do_reset();
        #1;
        chk("rst_count", {27'd0, bus.count}, 32'd0);
        chk("rst_en",    {31'd0, bus.mem_wr_en}, 32'd0);
        chk("rst_addr",  bus.mem_wr_addr, 32'd0);
        chk("rst_err",   {31'd0, bus.err}, 32'd0);

        // Basic push -> commit -> drain two cycles after push.
        push(4'd3, 32'h100, 32'hAA);
        commit(4'd3);
        #1;
        chk("t1_en",   {31'd0, bus.mem_wr_en}, 32'd1);
        chk("t1_addr", bus.mem_wr_addr, 32'h100);
        chk("t1_data", bus.mem_wr_data, 32'hAA);
        step();
        chk("t1_cnt",  {27'd0, bus.count}, 32'd0);

        // Flush keeps committed tags 1,2 and drops uncommitted 3.
        bus.stall = 1'b1;
        push(4'd1, 32'h10, 32'h1);
        push(4'd2, 32'h20, 32'h2);
        push(4'd3, 32'h30, 32'h3);
        commit(4'd1);
        commit(4'd2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t2_cnt", {27'd0, bus.count}, 32'd2);
        bus.ld_check_addr = 32'h30;
        #1;
        chk("t2_conf3", {31'd0, bus.ld_conflict}, 32'd0);
        bus.ld_check_addr = 32'h10;
        #1;
        chk("t2_conf1", {31'd0, bus.ld_conflict}, 32'd1);
        bus.stall = 1'b0;
        #1;
        chk("t2_d1", bus.mem_wr_addr, 32'h10);
        chk("t2_en1", {31'd0, bus.mem_wr_en}, 32'd1);
        step();
        #1;
        chk("t2_d2", bus.mem_wr_addr, 32'h20);
        step();
        chk("t2_cnt0", {27'd0, bus.count}, 32'd0);

        // Loads then stall hold off a committed head for 5 cycles.
        push(4'd7, 32'h40, 32'h77);
        commit(4'd7);
        bus.ld_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_ld", {31'd0, bus.mem_wr_en}, 32'd0);
            step();
        end
        bus.ld_ready = 1'b0;
        bus.stall    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t3_st", {31'd0, bus.mem_wr_en}, 32'd0);
            step();
        end
        bus.stall = 1'b0;
        #1;
        chk("t3_en",   {31'd0, bus.mem_wr_en}, 32'd1);
        chk("t3_data", bus.mem_wr_data, 32'h77);
        step();
        chk("t3_cnt", {27'd0, bus.count}, 32'd0);

        // Fill, overflow, drain all, wrap.
        do_reset();
        for (int i = 0; i < 16; i++) push(4'(i), 32'h1000 + 32'(i) * 4, 32'(i));
        chk("t4_full", {31'd0, bus.full}, 32'd1);
        push(4'd0, 32'hDEAD, 32'hDEAD);
        chk("t4_err", {31'd0, bus.err}, 32'd1);
        chk("t4_cnt", {27'd0, bus.count}, 32'd16);
        for (int i = 0; i < 16; i++) commit(4'(i));
        step();
        step();
        step();
        chk("t4_empty", {27'd0, bus.count}, 32'd0);
        chk("t4_head", {27'd0, dut.r_head}, 32'd16);
        chk("t4_tail", {27'd0, dut.r_tail}, 32'd16);
        push(4'd9, 32'hBEEF0, 32'h5);
        chk("t4_slot0", dut.r_addr[0], 32'hBEEF0);
        chk("t4_tail1", {27'd0, dut.r_tail}, 32'd17);

        // Out-of-order commit is rejected.
        do_reset();
        push(4'd5, 32'h50, 32'h5);
        push(4'd6, 32'h60, 32'h6);
        commit(4'd6);
        chk("t5_err", {31'd0, bus.err}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            #1 chk("t5_en", {31'd0, bus.mem_wr_en}, 32'd0);
            step();
        end
        chk("t5_cnt", {27'd0, bus.count}, 32'd2);

        // Load conflict on a pending store, cleared after drain.
        do_reset();
        push(4'd1, 32'h200, 32'h22);
        bus.ld_check_addr = 32'h200;
        #1;
        chk("t6_hit", {31'd0, bus.ld_conflict}, 32'd1);
        bus.ld_check_addr = 32'h204;
        #1;
        chk("t6_miss", {31'd0, bus.ld_conflict}, 32'd0);
        bus.ld_check_addr = 32'h200;
        commit(4'd1);
        step();
        #1;
        chk("t6_gone", {31'd0, bus.ld_conflict}, 32'd0);
        chk("t6_err", {31'd0, bus.err}, 32'd0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

Holds executed stores between address/data resolution and ROB commit, then drains committed stores in program order onto the `rob_mem_wr` write port of the memory reservation station. It is the producer end of that interface: it generates `mem_wr_en`/`mem_wr_addr`/`mem_wr_data`, and it yields the d-cache port to pending loads. It also answers load-vs-pending-store address conflict queries, and it discards speculative stores on a branch flush.

## Interface
- `DEPTH`, 16: number of entries; a power of 2, equal to `ROB_DEPTH`.
- `TAG_BITS`, 4: ROB tag width, equal to `ROB_DEPTH_BITS`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `st_valid`  in  1  executed store ready to enter the buffer.
- `st_tag`  in  TAG_BITS  ROB tag of that store.
- `st_addr`  in  32  store byte address.
- `st_data`  in  32  store data.
- `commit_store`  in  1  ROB is retiring a store this cycle.
- `commit_tag`  in  TAG_BITS  ROB tag of the retiring store.
- `flush`  in  1  branch mispredict flush.
- `stall`  in  1  memory-stage hazard stall.
- `ld_ready`  in  1  the reservation station is issuing a load this cycle; loads have priority.
- `ld_check_addr`  in  32  address of a candidate load.
- `ld_conflict`  out  1  some valid entry has `addr == ld_check_addr`; combinational.
- `mem_wr_en`  out  1  committed store presented this cycle.
- `mem_wr_addr`  out  32  head entry address.
- `mem_wr_data`  out  32  head entry data.
- `full`  out  1  count == DEPTH.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `err`  out  1  sticky protocol error.

## Operation
- Storage is a circular FIFO of entries `{valid, committed, tag, addr, data}`.
- Pointers `head`, `tail` and `cmt` (oldest uncommitted) are each $clog2(DEPTH)+1 bits wide, with the MSB as wrap bit. All pointer arithmetic is modulo 2·DEPTH.
- Push: `st_valid & !full & !flush` writes an entry at `tail` with `valid=1` and `committed=0`, then `tail++`.
  - `st_valid & full` drops the store and sets `err`.
  - Push uses `full` from the pre-edge state; a simultaneous pop does not free a slot for it.
- Commit: `commit_store` must match the entry at `cmt`. This requires `cmt != tail` and `entry[cmt].tag == commit_tag`.
  - On a match: set `committed`, then `cmt++`.
  - On a mismatch, or when no uncommitted entry exists: no state change, set `err`.
  - A commit that arrives in the same cycle as the push of the same tag is a mismatch.
- Drain: `mem_wr_en = entry[head].valid & entry[head].committed & !stall & !ld_ready`.
  - When `mem_wr_en` is high, `head++` and `entry[head].valid` is cleared at the edge.
  - `mem_wr_addr` and `mem_wr_data` always show the head entry; they are 0 when the buffer is empty.
- Flush: uncommitted entries are discarded and committed entries are kept, because they are architectural.
  - Next `tail = cmt`, after applying any same-cycle commit. Valid bits of discarded slots are cleared.
  - A push in the flush cycle is dropped. Commit and drain in the flush cycle proceed normally.
- `ld_conflict` compares all 32 address bits against every valid entry, committed or not.
- `count = tail - head`.
- `err` is cleared only by reset.

## Timing
- Reset: all entries invalid; `head = tail = cmt = 0`. Outputs: `mem_wr_en=0`, `mem_wr_addr=0`, `mem_wr_data=0`, `full=0`, `count=0`, `ld_conflict=0`, `err=0`.
- Store pushed at edge N can be committed in cycle N+1 at the earliest. It can be presented on `mem_wr_en` in cycle N+2 at the earliest.
- `mem_wr_en` is combinational from registered state plus `stall`/`ld_ready`. The consumer latches the write at the same edge the buffer pops.
- Throughput is one drain per cycle when not stalled. A drain and a push in the same cycle leave `count` unchanged.
- Wrap: pointers roll from 2·DEPTH-1 to 0. Full/empty is decided by equal index bits plus the wrap bit.
- Reset mid-operation discards all entries, including committed ones.

## Test plan
- Store tag 3, addr 0x100, data 0xAA, then commit tag 3 → `mem_wr_en=1` two cycles after the push with addr 0x100 and data 0xAA; `count` returns to 0.
- Push tags 1, 2, 3; commit 1 and 2; assert `flush` → `count=2`; tag 3 gone; drains 1 then 2; `ld_conflict=0` for tag 3's address.
- Committed head with `ld_ready=1` for 3 cycles, then `stall=1` for 2 cycles → `mem_wr_en=0` for all 5 cycles, then 1; no entry is lost.
- Fill 16 entries, then push a 17th → `full=1`; the 17th is dropped and `err=1`. Commit and drain 16 → pointers wrap and the next push lands at index 0.
- Push tags 5 and 6; commit tag 6 first → `err=1`; nothing becomes committed; `mem_wr_en` stays 0.
- Pending store at 0x200 with `ld_check_addr=0x200` → `ld_conflict=1`; with 0x204 → 0; after that store drains, 0x200 gives 0.
